// File: rtl/pulse_period_meter.sv
// Measures the number of clk cycles spanning NPER periods of an asynchronous pulse stream,
// reporting each result with a one-cycle valid strobe and a saturation flag.
module pulse_period_meter #(
  parameter int CNT_BITS    = 24,
  parameter int NPER        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pulse_in,
  input  logic                enable,
  output logic [CNT_BITS-1:0] period,
  output logic                valid,
  output logic                overflow,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [7:0]          NPER_M1 = 8'(NPER - 1);

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                  dly_q, dly_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [CNT_BITS-1:0]   cnt_inc;
  logic [7:0]            per_cnt_q, per_cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [CNT_BITS-1:0]   period_q, period_d;
  logic                  overflow_q, overflow_d;
  logic                  valid_q, valid_d;
  logic                  rise;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  assign rise    = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_cnt_d  = per_cnt_q;
    ovf_pend_d = ovf_pend_q;
    period_d   = period_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        per_cnt_d  = '0;
        ovf_pend_d = 1'b0;
        if (enable) state_d = ARM;
      end
      ARM: begin
        cnt_d      = '0;
        per_cnt_d  = '0;
        ovf_pend_d = 1'b0;
        if (rise) begin
          state_d = MEAS;
          cnt_d   = CNT_ONE;
        end
      end
      MEAS: begin
        // A terminating edge reports and restarts in the same cycle, so there is no dead time.
        if (rise && per_cnt_q == NPER_M1) begin
          period_d   = cnt_q;
          overflow_d = ovf_pend_q;
          valid_d    = 1'b1;
          cnt_d      = CNT_ONE;
          per_cnt_d  = '0;
          ovf_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) ovf_pend_d = 1'b1;
          if (rise) per_cnt_d = per_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropping enable wins over everything, including a coincident terminating edge.
    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      per_cnt_d  = '0;
      ovf_pend_d = 1'b0;
      period_d   = period_q;
      overflow_d = overflow_q;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      dly_q      <= 1'b0;
      cnt_q      <= '0;
      per_cnt_q  <= '0;
      ovf_pend_q <= 1'b0;
      period_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
      per_cnt_q  <= per_cnt_d;
      ovf_pend_q <= ovf_pend_d;
      period_q   <= period_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign period   = period_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == MEAS);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench: two meters (8-bit/NPER=1 and 24-bit/NPER=4) driven with directed pulse trains.
module tb_pulse_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_a = 1'b0, pulse_b = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [7:0]  period_a;
  logic [23:0] period_b;
  logic        valid_a, valid_b, overflow_a, overflow_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  exp_a[$];
  logic [24:0] exp_b[$];

  pulse_period_meter #(.CNT_BITS(8), .NPER(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .pulse_in(pulse_a), .enable(en_a),
    .period(period_a), .valid(valid_a), .overflow(overflow_a), .busy(busy_a)
  );

  pulse_period_meter #(.CNT_BITS(24), .NPER(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .pulse_in(pulse_b), .enable(en_b),
    .period(period_b), .valid(valid_b), .overflow(overflow_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setPulse(input bit which, input logic v);
    if (which) pulse_b = v;
    else       pulse_a = v;
  endtask

  // Each period starts with a rising edge: high for 'high' cycles, then low for 'low' cycles.
  task automatic applyStimulus(input bit which, input int high, input int low, input int n);
    for (int i = 0; i < n; i++) begin
      setPulse(which, 1'b1);
      waitCycles(high);
      setPulse(which, 1'b0);
      waitCycles(low);
    end
  endtask

  task automatic drainCheck(input string name);
    waitCycles(6);
    checkOutput({name, " exp_a drained"}, exp_a.size(), 0);
    checkOutput({name, " exp_b drained"}, exp_b.size(), 0);
  endtask

  always @(negedge clk) begin : mon_a
    logic [8:0] e;
    if (valid_a) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected valid_a: period %0d, none expected at %0t", period_a, $time);
      end else begin
        e = exp_a.pop_front();
        checkOutput("period_a", {24'd0, period_a}, {24'd0, e[7:0]});
        checkOutput("overflow_a", {31'd0, overflow_a}, {31'd0, e[8]});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [24:0] e;
    if (valid_b) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected valid_b: period %0d, none expected at %0t", period_b, $time);
      end else begin
        e = exp_b.pop_front();
        checkOutput("period_b", {8'd0, period_b}, {8'd0, e[23:0]});
        checkOutput("overflow_b", {31'd0, overflow_b}, {31'd0, e[24]});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held three cycles while the input toggles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_a = i[0];
      waitCycles(1);
      checkOutput("reset period_a", {24'd0, period_a}, 32'd0);
      checkOutput("reset valid_a", {31'd0, valid_a}, 32'd0);
      checkOutput("reset overflow_a", {31'd0, overflow_a}, 32'd0);
      checkOutput("reset busy_a", {31'd0, busy_a}, 32'd0);
      checkOutput("reset busy_b", {31'd0, busy_b}, 32'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 3, 3, 4);
    checkOutput("disabled busy_a", {31'd0, busy_a}, 32'd0);
    checkOutput("disabled period_a", {24'd0, period_a}, 32'd0);
    drainCheck("disabled");

    // Basic period: 5 high / 5 low, four rising edges give three results of 10.
    en_a = 1'b1;
    waitCycles(3);
    repeat (3) exp_a.push_back({1'b0, 8'd10});
    applyStimulus(1'b0, 5, 5, 4);
    checkOutput("basic busy_a", {31'd0, busy_a}, 32'd1);
    drainCheck("basic");
    en_a = 1'b0;
    waitCycles(2);

    // Multi-period: NPER=4, 3 high / 4 low, nine edges give two results of 28.
    en_b = 1'b1;
    waitCycles(3);
    repeat (2) exp_b.push_back({1'b0, 24'd28});
    applyStimulus(1'b1, 3, 4, 9);
    drainCheck("multi");
    en_b = 1'b0;
    waitCycles(2);

    // Enable abort five cycles into a measurement; edges while disabled are ignored.
    en_a = 1'b1;
    waitCycles(3);
    pulse_a = 1'b1;
    waitCycles(5);
    pulse_a = 1'b0;
    waitCycles(3);
    checkOutput("abort busy before", {31'd0, busy_a}, 32'd1);
    en_a = 1'b0;
    waitCycles(1);
    checkOutput("abort busy_a", {31'd0, busy_a}, 32'd0);
    checkOutput("abort period hold", {24'd0, period_a}, 32'd10);
    checkOutput("abort overflow hold", {31'd0, overflow_a}, 32'd0);
    waitCycles(2);
    pulse_a = 1'b1;
    waitCycles(4);
    pulse_a = 1'b0;
    waitCycles(3);
    checkOutput("abort period still", {24'd0, period_a}, 32'd10);
    en_a = 1'b1;
    waitCycles(4);
    repeat (2) exp_a.push_back({1'b0, 8'd20});
    applyStimulus(1'b0, 10, 10, 3);
    drainCheck("abort");
    en_a = 1'b0;
    waitCycles(2);

    // Overflow: a 300-cycle period saturates the 8-bit counter, then a 20-cycle period recovers.
    en_a = 1'b1;
    waitCycles(3);
    exp_a.push_back({1'b1, 8'd255});
    exp_a.push_back({1'b0, 8'd20});
    applyStimulus(1'b0, 150, 150, 1);
    applyStimulus(1'b0, 10, 10, 2);
    drainCheck("overflow");
    en_a = 1'b0;
    waitCycles(2);

    // Reset mid-measurement, right after a saturated result, then re-measure 12 cycles.
    en_a = 1'b1;
    waitCycles(3);
    exp_a.push_back({1'b1, 8'd255});
    applyStimulus(1'b0, 150, 150, 1);
    pulse_a = 1'b1;
    waitCycles(6);
    pulse_a = 1'b0;
    waitCycles(3);
    checkOutput("pre-reset overflow_a", {31'd0, overflow_a}, 32'd1);
    checkOutput("pre-reset busy_a", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("midrst period_a", {24'd0, period_a}, 32'd0);
    checkOutput("midrst valid_a", {31'd0, valid_a}, 32'd0);
    checkOutput("midrst overflow_a", {31'd0, overflow_a}, 32'd0);
    checkOutput("midrst busy_a", {31'd0, busy_a}, 32'd0);
    checkOutput("midrst period_b", {8'd0, period_b}, 32'd0);
    rst = 1'b0;
    waitCycles(3);
    repeat (2) exp_a.push_back({1'b0, 8'd12});
    applyStimulus(1'b0, 6, 6, 3);
    drainCheck("midrst");
    en_a = 1'b0;
    waitCycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Receive-side companion to the clock-divider pulse generators in the counter design. It takes a single-bit pulse stream (a divider's carry-out or an external input), synchronizes it into the `clk` domain and detects rising edges. It counts `clk` cycles across NPER consecutive input periods and reports each result with a one-cycle `valid` strobe. It is used to close the loop on divider outputs and to measure external frequency sources.

## Interface
- `CNT_BITS`, 24: width of the cycle counter and of `period`.
- `NPER`, 1: input periods per measurement; legal range 1..255.
- `SYNC_STAGES`, 2: synchronizer flops on `pulse_in`; minimum 2.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pulse_in`  in  1  asynchronous pulse stream to be measured.
- `enable`  in  1  1 = measure; 0 = idle and discard any partial measurement.
- `period`  out  CNT_BITS  `clk` cycles spanning the last NPER input periods; holds until the next result.
- `valid`  out  1  one-cycle strobe; `period` and `overflow` update on the same cycle.
- `overflow`  out  1  last result saturated; updates only with `valid`.
- `busy`  out  1  1 while in MEAS.

## Operation
- **Synchronizer:** `pulse_in` passes through a SYNC_STAGES flop chain, then one more delay flop.
  - `rise` = last sync stage & ~delay flop (combinational).
- **State machine:** three states, IDLE / ARM / MEAS.
- **IDLE:** entered on reset or whenever `enable`=0. Counters are held at 0.
  - `enable`=1 → ARM.
- **ARM:** waits for the start edge.
  - On `rise` → MEAS, `cnt`←1, `per_cnt`←0, overflow-pending←0.
- **MEAS:** each cycle without `rise`, `cnt`←`cnt`+1, saturating at 2^CNT_BITS−1.
  - Reaching all-ones sets overflow-pending.
- **Rise in MEAS, non-terminating** (`per_cnt`+1 < NPER): `per_cnt`←`per_cnt`+1 and `cnt` keeps incrementing.
- **Rise in MEAS, terminating** (`per_cnt`+1 = NPER):
  - Outputs: `period`←`cnt`, `overflow`←overflow-pending, `valid`←1.
  - Restart in the same cycle: `cnt`←1, `per_cnt`←0, overflow-pending←0; stay in MEAS. There is zero dead time between measurements.
- **Result value:** edges P cycles apart with NPER=1 give `period`=P. The general result is the sum of NPER periods, saturating.
- **`enable` falls:** → IDLE on that edge.
  - Any partial measurement is discarded.
  - `period` and `overflow` hold their last values; `valid` stays 0.
  - `enable` beats a coincident terminating `rise`: no `valid` is produced.
- **`pulse_in` stuck high or low:** no `rise`, so `cnt` saturates and no `valid` is produced. `busy` remains 1.
- **Input pulse width:** high and low phases must each be ≥2 `clk` cycles to guarantee detection. Narrower pulses may be missed; this is not flagged.
- **`per_cnt`:** 8 bits wide.

## Timing
- **Reset:** `period`=0, `valid`=0, `overflow`=0, `busy`=0, state IDLE, all synchronizer flops 0.
- **`rst` mid-measurement:** all of the above on the next edge. Measurement restarts through ARM; the first `valid` needs two further edges when NPER=1.
- **Latency:**
  - `pulse_in` first sampled high at edge k → `rise` is high during the cycle after edge k+SYNC_STAGES−1.
  - `valid` is high in the cycle after edge k+SYNC_STAGES.
- **`valid` width:** exactly one cycle. Repeat rate is one per NPER input periods.
- **`busy`:** rises on the edge that consumes the start `rise`.
  - Falls on the edge after `enable`=0 is sampled, or on reset.
- **Enable to ARM:** `enable` 0→1 gives ARM on the next edge. A `rise` already pending in that cycle is ignored.

## Test plan
- **Reset:** hold `rst` 3 cycles with `pulse_in` toggling → `period`=0, `valid`=0, `overflow`=0, `busy`=0; no `valid` while `enable`=0.
- **Basic period:** NPER=1, `enable`=1, `pulse_in` 5 high/5 low → first `valid` after the second rising edge with `period`=10. Then `valid` every 10 cycles, `overflow`=0.
- **Multi-period average:** NPER=4, `pulse_in` 3 high/4 low → `period`=28, `valid` every 28 cycles.
- **Overflow:** CNT_BITS=8, `pulse_in` period 300 → `period`=255, `overflow`=1. After switching to period 20 → `period`=20, `overflow`=0.
- **Enable abort:** drop `enable` 5 cycles into MEAS, reassert 10 cycles later → no `valid` meanwhile, `busy`=0, `period` holds its old value. Next `valid` comes after two new edges with the true period.
- **Reset mid-measurement:** assert `rst` mid-MEAS → next cycle all outputs 0 and IDLE. With `enable`=1 it re-arms, and the first result equals the exact input period.
